// File: rtl/count_seq_pkg.sv
// -----------------------------------------------------------------------------
// count_seq_pkg
//   Shared definitions for the count sequencer slice: the FSM state encoding
//   and the default counter width. Every file of the slice imports this
//   package so the encoding lives in exactly one place.
// -----------------------------------------------------------------------------
package count_seq_pkg;

  // Default counter width used by count_sequencer and count_seq_counter.
  localparam int WIDTH_DEFAULT = 4;

  // Sequencer states. The numeric encoding is visible to anyone probing the
  // state register, so it is fixed explicitly rather than left to the tool.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : count_seq_pkg

// File: rtl/count_seq_counter.sv
// -----------------------------------------------------------------------------
// count_seq_counter
//   WIDTH-bit up counter with synchronous clear and count enable.
//   Clear wins over enable. The increment wraps modulo 2^WIDTH; there is no
//   other wrap or load path.
//
// Ports
//   iClk    in   clock, rising edge
//   iRst    in   asynchronous active-low reset, forces the count to 0
//   iClr    in   synchronous clear to 0 (priority over iEn)
//   iEn     in   increment by one on the next rising edge
//   oCount  out  registered count value
// -----------------------------------------------------------------------------
module count_seq_counter
  import count_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClr,
  input  logic             iEn,
  output logic [WIDTH-1:0] oCount
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] rCount;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rCount <= '0;
    end else if (iClr) begin
      rCount <= '0;
    end else if (iEn) begin
      rCount <= rCount + ONE;
    end
  end

  assign oCount = rCount;

endmodule : count_seq_counter

// File: rtl/count_sequencer.sv
// -----------------------------------------------------------------------------
// count_sequencer
//   Four-state (IDLE/RUN/HOLD/DONE) count sequencer. An accepted start latches
//   the terminal count and mode, clears the counter and enters RUN. In RUN the
//   counter increments once per cycle until it equals the latched limit; then
//   one-shot mode parks in DONE holding the limit, auto-reload mode clears to 0
//   and keeps running. Either way a one-cycle terminal-count pulse follows.
//   iHold freezes the count (RUN -> HOLD), iAbort returns to IDLE from any
//   state and has the highest priority.
//
//   All outputs come from registers or from the state register alone, so
//   there is no combinational path from any input to any output.
//
// Ports
//   iClk     in   clock, rising edge
//   iRst     in   asynchronous active-low reset
//   iStart   in   start request, sampled only in IDLE and DONE
//   iAbort   in   return to IDLE, count 0, from any state
//   iHold    in   freeze the count while running
//   iMode    in   0 = one-shot, 1 = auto-reload (latched on accepted start)
//   iLimit   in   terminal count (latched on accepted start)
//   oSalida  out  current count value
//   oTc      out  one-cycle terminal-count pulse
//   oBusy    out  high in RUN or HOLD
//   oDone    out  high in DONE
// -----------------------------------------------------------------------------
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic             iHold,
  input  logic             iMode,
  input  logic [WIDTH-1:0] iLimit,
  output logic [WIDTH-1:0] oSalida,
  output logic             oTc,
  output logic             oBusy,
  output logic             oDone
);

  state_t           rState;
  state_t           sNext;

  logic [WIDTH-1:0] rLimit;
  logic             rMode;
  logic             rTc;
  logic [WIDTH-1:0] count;

  logic             atLimit;
  logic             accept;
  logic             cntClr;
  logic             cntEn;
  logic             tcNext;

  assign atLimit = (count == rLimit);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rState <= IDLE;
    end else begin
      rState <= sNext;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Abort overrides everything, then hold, then the
  // terminal-count decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    sNext = rState;
    if (iAbort) begin
      sNext = IDLE;
    end else begin
      case (rState)
        IDLE: if (iStart) sNext = RUN;
        RUN: begin
          if (iHold) begin
            sNext = HOLD;
          end else if (atLimit && !rMode) begin
            sNext = DONE;
          end
        end
        HOLD: if (!iHold) sNext = RUN;
        DONE: if (iStart) sNext = RUN;
        default: sNext = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Counter control and terminal-count detection.
  //   - The counter is cleared continuously in IDLE so it always reads 0 there.
  //   - Leaving HOLD does not increment: the count resumes on the edge after
  //     the FSM is back in RUN.
  //   - In one-shot mode the count simply stops at the limit (no clear, no
  //     enable), which is how DONE holds the limit value.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept = 1'b0;
    cntClr = 1'b0;
    cntEn  = 1'b0;
    tcNext = 1'b0;
    if (iAbort) begin
      cntClr = 1'b1;
    end else begin
      case (rState)
        IDLE: begin
          cntClr = 1'b1;
          accept = iStart;
        end
        RUN: begin
          if (!iHold) begin
            if (atLimit) begin
              tcNext = 1'b1;
              cntClr = rMode;
            end else begin
              cntEn = 1'b1;
            end
          end
        end
        HOLD: begin
          cntEn = 1'b0;
        end
        DONE: begin
          accept = iStart;
          cntClr = iStart;
        end
        default: cntClr = 1'b1;
      endcase
    end
  end

  // Limit/mode capture and the registered terminal-count pulse.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      rLimit <= '0;
      rMode  <= 1'b0;
      rTc    <= 1'b0;
    end else begin
      if (accept) begin
        rLimit <= iLimit;
        rMode  <= iMode;
      end
      rTc <= tcNext;
    end
  end

  count_seq_counter #(
    .WIDTH (WIDTH)
  ) uCounter (
    .iClk   (iClk),
    .iRst   (iRst),
    .iClr   (cntClr),
    .iEn    (cntEn),
    .oCount (count)
  );

  // ---------------------------------------------------------------------------
  // Output decode: state-only flags plus registered count and pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    oSalida = count;
    oTc     = rTc;
    oBusy   = (rState == RUN) || (rState == HOLD);
    oDone   = (rState == DONE);
  end

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// -----------------------------------------------------------------------------
// tb_count_sequencer
//   Directed, table-driven bench for count_sequencer (WIDTH = 4). Each table
//   row gives the inputs applied for one clock edge and the outputs expected
//   after that edge. Hand-written sequences cover asynchronous reset mid-run
//   and the full-range auto-reload wrap.
// -----------------------------------------------------------------------------
module tb_count_sequencer;

  localparam int W = 4;

  logic         iClk;
  logic         iRst;
  logic         iStart;
  logic         iAbort;
  logic         iHold;
  logic         iMode;
  logic [W-1:0] iLimit;
  logic [W-1:0] oSalida;
  logic         oTc;
  logic         oBusy;
  logic         oDone;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic         start;
    logic         abort;
    logic         hold;
    logic         mode;
    logic [W-1:0] limit;
    logic [W-1:0] expCnt;
    logic         expTc;
    logic         expBusy;
    logic         expDone;
  } vec_t;

  localparam int NVEC = 40;
  vec_t vecs [NVEC];

  count_sequencer #(.WIDTH(W)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iAbort  (iAbort),
    .iHold   (iHold),
    .iMode   (iMode),
    .iLimit  (iLimit),
    .oSalida (oSalida),
    .oTc     (oTc),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic vec_t mk(input logic s, input logic a, input logic h,
                              input logic m, input logic [W-1:0] l,
                              input logic [W-1:0] c, input logic tc,
                              input logic b, input logic d);
    vec_t v;
    v.start = s; v.abort = a; v.hold = h; v.mode = m; v.limit = l;
    v.expCnt = c; v.expTc = tc; v.expBusy = b; v.expDone = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic [W-1:0] c,
                          input logic tc, input logic b, input logic d);
    check({tag, " cnt"},  32'(oSalida), 32'(c));
    check({tag, " tc"},   32'(oTc),     32'(tc));
    check({tag, " busy"}, 32'(oBusy),   32'(b));
    check({tag, " done"}, 32'(oDone),   32'(d));
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next
  // falling edge, i.e. half a cycle after the rising edge that used them.
  task automatic step(input logic s, input logic a, input logic h,
                      input logic m, input logic [W-1:0] l);
    iStart = s; iAbort = a; iHold = h; iMode = m; iLimit = l;
    @(posedge iClk);
    @(negedge iClk);
  endtask

  initial begin : main
    logic [W-1:0] expCnt;
    logic         expTc;
    logic         prevTc;
    int           tcCount;

    // 5-then-DONE one-shot run with an ignored limit change.
    vecs[0]  = mk(1,0,0,0,4'd5, 4'd0,0,1,0);
    vecs[1]  = mk(0,0,0,0,4'd9, 4'd1,0,1,0);
    vecs[2]  = mk(0,0,0,1,4'd9, 4'd2,0,1,0);
    vecs[3]  = mk(0,0,0,0,4'd0, 4'd3,0,1,0);
    vecs[4]  = mk(0,0,0,0,4'd0, 4'd4,0,1,0);
    vecs[5]  = mk(0,0,0,0,4'd0, 4'd5,0,1,0);
    vecs[6]  = mk(0,0,0,0,4'd0, 4'd5,1,0,1);
    vecs[7]  = mk(0,0,0,0,4'd0, 4'd5,0,0,1);
    // Restart from DONE into auto-reload with limit 3; start ignored in RUN.
    vecs[8]  = mk(1,0,0,1,4'd3, 4'd0,0,1,0);
    vecs[9]  = mk(0,0,0,0,4'd0, 4'd1,0,1,0);
    vecs[10] = mk(0,0,0,0,4'd0, 4'd2,0,1,0);
    vecs[11] = mk(0,0,0,0,4'd0, 4'd3,0,1,0);
    vecs[12] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    vecs[13] = mk(0,0,0,0,4'd0, 4'd1,0,1,0);
    vecs[14] = mk(0,0,0,0,4'd0, 4'd2,0,1,0);
    vecs[15] = mk(0,0,0,0,4'd0, 4'd3,0,1,0);
    vecs[16] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    vecs[17] = mk(0,0,0,0,4'd0, 4'd1,0,1,0);
    vecs[18] = mk(1,0,0,0,4'd7, 4'd2,0,1,0);
    vecs[19] = mk(0,0,0,0,4'd0, 4'd3,0,1,0);
    vecs[20] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    // Abort beats hold; start together with abort stays in IDLE.
    vecs[21] = mk(0,1,1,0,4'd0, 4'd0,0,0,0);
    vecs[22] = mk(1,1,0,0,4'd6, 4'd0,0,0,0);
    // Limit 0, one-shot: DONE after one RUN cycle.
    vecs[23] = mk(1,0,0,0,4'd0, 4'd0,0,1,0);
    vecs[24] = mk(0,0,0,0,4'd0, 4'd0,1,0,1);
    // Limit 0, auto-reload: pulse every cycle.
    vecs[25] = mk(1,0,0,1,4'd0, 4'd0,0,1,0);
    vecs[26] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    vecs[27] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    vecs[28] = mk(0,0,0,0,4'd0, 4'd0,1,1,0);
    vecs[29] = mk(0,1,0,0,4'd0, 4'd0,0,0,0);
    // Limit 7 with a 3-cycle hold at count 2, then abort+hold at count 4.
    vecs[30] = mk(1,0,0,0,4'd7, 4'd0,0,1,0);
    vecs[31] = mk(0,0,0,0,4'd0, 4'd1,0,1,0);
    vecs[32] = mk(0,0,0,0,4'd0, 4'd2,0,1,0);
    vecs[33] = mk(0,0,1,0,4'd0, 4'd2,0,1,0);
    vecs[34] = mk(0,0,1,0,4'd0, 4'd2,0,1,0);
    vecs[35] = mk(0,0,1,0,4'd0, 4'd2,0,1,0);
    vecs[36] = mk(0,0,0,0,4'd0, 4'd2,0,1,0);
    vecs[37] = mk(0,0,0,0,4'd0, 4'd3,0,1,0);
    vecs[38] = mk(0,0,0,0,4'd0, 4'd4,0,1,0);
    vecs[39] = mk(0,1,1,0,4'd0, 4'd0,0,0,0);

    iRst = 1'b0; iStart = 1'b0; iAbort = 1'b0; iHold = 1'b0;
    iMode = 1'b0; iLimit = '0;

    // Reset held across clock edges.
    @(negedge iClk);
    @(negedge iClk);
    checkAll("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    iRst = 1'b1;
    step(0,0,0,0,4'd0);
    checkAll("post-reset idle", 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].start, vecs[i].abort, vecs[i].hold, vecs[i].mode,
           vecs[i].limit);
      checkAll($sformatf("vec%0d", i), vecs[i].expCnt, vecs[i].expTc,
               vecs[i].expBusy, vecs[i].expDone);
    end

    // Asynchronous reset pulsed between edges in the middle of a run.
    step(1,0,0,1,4'd9);
    step(0,0,0,0,4'd0);
    step(0,0,0,0,4'd0);
    step(0,0,0,0,4'd0);
    checkAll("pre-async", 4'd3, 1'b0, 1'b1, 1'b0);
    #2 iRst = 1'b0;
    #1 checkAll("async-reset immediate", 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge iClk);
    @(negedge iClk);
    checkAll("async-reset held", 4'd0, 1'b0, 1'b0, 1'b0);
    iRst = 1'b1;
    step(0,0,0,0,4'd0);
    checkAll("async-reset released", 4'd0, 1'b0, 1'b0, 1'b0);

    // Full-range auto-reload: wrap 15 -> 0 with one pulse per 16 cycles.
    step(1,0,0,1,4'd15);
    checkAll("full start", 4'd0, 1'b0, 1'b1, 1'b0);
    expCnt  = 4'd0;
    prevTc  = 1'b0;
    tcCount = 0;
    for (int k = 0; k < 40; k++) begin
      expTc  = (expCnt == 4'd15);
      expCnt = expTc ? 4'd0 : expCnt + 4'd1;
      step(0,0,0,0,4'd3);
      checkAll($sformatf("full%0d", k), expCnt, expTc, 1'b1, 1'b0);
      check($sformatf("full%0d tc-consecutive", k),
            32'(prevTc & oTc), 32'd0);
      if (oTc) tcCount++;
      prevTc = oTc;
    end
    check("full tc pulse count", 32'(tcCount), 32'd2);

    step(0,1,0,0,4'd0);
    checkAll("final abort", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have port iClk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port iRst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port iStart, input, 1 bit: start a count sequence; sampled in IDLE and DONE only.
REQ-005 SHALL have port iAbort, input, 1 bit: return to IDLE from any state.
REQ-006 SHALL have port iHold, input, 1 bit: freeze the count while in RUN.
REQ-007 SHALL have port iMode, input, 1 bit: 0 = one-shot, 1 = auto-reload; latched with iLimit.
REQ-008 SHALL have port iLimit, input, WIDTH bits: terminal count value; latched on an accepted start.
REQ-009 SHALL have port oSalida, output, WIDTH bits: current count value.
REQ-010 SHALL have port oTc, output, 1 bit: one-cycle terminal-count pulse.
REQ-011 SHALL have port oBusy, output, 1 bit: high in RUN or HOLD.
REQ-012 SHALL have port oDone, output, 1 bit: high in DONE.

Function
REQ-013 SHALL implement a four-state FSM with states IDLE, RUN, HOLD and DONE; all outputs are registered or decoded from state only, with no combinational path from input to output.
REQ-014 IDLE: count = 0; on iStart, latch iLimit and iMode, clear count to 0, and go to RUN on the next edge.
REQ-015 RUN, iHold = 0, count != rLimit: count increments by 1 per cycle.
REQ-016 RUN, iHold = 0, count == rLimit, mode 1: count goes to 0, FSM stays in RUN, and oTc = 1 in the following cycle.
REQ-017 RUN, iHold = 0, count == rLimit, mode 0: count holds at rLimit, FSM goes to DONE, and oTc = 1 in the following cycle.
REQ-018 RUN with iHold = 1 SHALL go to HOLD with count unchanged; HOLD SHALL return to RUN on the first cycle iHold = 0, and the count resumes incrementing on the edge after that.
REQ-019 DONE: count holds rLimit and oDone = 1; iStart relatches iLimit and iMode, clears count to 0, and goes to RUN.
REQ-020 iStart SHALL be ignored in RUN and HOLD, and iLimit and iMode changes SHALL be ignored outside an accepted start.
REQ-021 Priority SHALL be iAbort > iHold > terminal-count/increment; iAbort in any state SHALL give IDLE, count 0 and oTc 0 on the next edge.
REQ-022 rLimit = 0 SHALL make the terminal condition true on the first RUN cycle: in mode 1, oTc fires every cycle; in mode 0, the FSM enters DONE after 1 cycle.
REQ-023 rLimit = 2^WIDTH-1 SHALL count the full range; the increment is modulo 2^WIDTH and no other wrap path exists.
REQ-024 oTc SHALL never be high for more than one consecutive cycle except under REQ-022, mode 1.

Reset
REQ-025 iRst low SHALL asynchronously force: state IDLE, count 0, rLimit 0, rMode 0, oTc 0, oBusy 0, oDone 0.
REQ-026 Deassertion of iRst SHALL take effect at the first rising iClk edge with iRst high; reset asserted mid-sequence SHALL discard the sequence.

Structure
REQ-027 SHALL define the state encoding (IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3) and the WIDTH default in shared package count_seq_pkg.
REQ-028 SHALL instantiate one sub-module, count_seq_counter (WIDTH-bit register with clear, enable and async active-low reset); the FSM and limit compare SHALL remain in count_sequencer.

Verification
REQ-029 Reset then a 1-cycle iStart with iLimit = 5 and iMode = 0 SHALL give oSalida 0,1,2,3,4,5, then oDone = 1 with a single oTc pulse, and oSalida held at 5.
REQ-030 iLimit = 3 with iMode = 1 over 12 RUN cycles SHALL give the sequence 0,1,2,3,0,1,..., with oTc pulses exactly 4 cycles apart and oBusy = 1 throughout.
REQ-031 iHold high for 3 cycles at count 2 (iLimit = 7) SHALL give oSalida = 2 for 4 cycles, with oBusy = 1, then resume at 3.
REQ-032 iAbort asserted together with iHold at count 4 SHALL give IDLE and oSalida = 0 on the next edge; iStart together with iAbort in IDLE SHALL leave the block in IDLE.
REQ-033 iRst pulsed low mid-RUN between clock edges SHALL give oSalida = 0 and oBusy = 0 immediately, with no oTc.
REQ-034 iLimit = 0 in mode 0 SHALL give DONE after 1 cycle; iLimit = 15 in mode 1 SHALL give a wrap from 15 to 0 with one oTc per 16 cycles.
